perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent valid/ready channels monitored, legal range 1..16.
REQ-002 Parameter CNT_W, default 16: width of each channel counter, legal range 2..32.
REQ-003 Parameter SAT_MODE, default 0: 0 = counters wrap to zero, 1 = counters saturate at all-ones.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  global count enable.
REQ-007 clear  input  1  synchronous clear of live counters and overflow flags.
REQ-008 valid  input  NUM_CH  per-channel source valid.
REQ-009 ready  input  NUM_CH  per-channel receiver ready.
REQ-010 ch_mode  input  2*NUM_CH  per-channel event select, channel i at bits [2i+1:2i].
REQ-011 snap_req  input  1  snapshot request; all live counters are copied to shadow registers.
REQ-012 rd_sel  input  max(1,$clog2(NUM_CH))  shadow register read index.
REQ-013 rd_data  output  CNT_W  shadow value of the selected channel.
REQ-014 snap_valid  output  1  one-cycle pulse marking a completed snapshot.
REQ-015 ovf  output  NUM_CH  sticky per-channel overflow flags.

Function
REQ-016 Channel event decode per ch_mode: OFF (0) never; XFER (1) valid&ready; STALL (2) valid&!ready; IDLE (3) !valid.
REQ-017 Decode is combinational from ch_mode in the current cycle, so a mode change takes effect on the same edge.
REQ-018 A live counter increments by exactly 1 on an edge where enable=1, clear=0 and its channel event is true; otherwise it holds.
REQ-019 SAT_MODE=0: a counter at 2^CNT_W-1 with an event goes to 0 and sets its ovf bit.
REQ-020 SAT_MODE=1: a counter at 2^CNT_W-1 with an event holds at all-ones and sets its ovf bit.
REQ-021 An ovf bit stays set until clear or reset; further overflows leave it at 1.
REQ-022 clear=1 zeroes all live counters and all ovf bits on the next edge, takes priority over increment, and discards the same-cycle event.
REQ-023 snap_req=1 loads every shadow register with the pre-edge live value, excluding any increment on that edge.
REQ-024 snap_valid pulses high for exactly one cycle, in the cycle after snap_req was sampled.
REQ-025 snap_req and clear together: the shadow registers capture the pre-clear values and the live counters become 0.
REQ-026 Back-to-back snap_req on consecutive cycles: each edge re-captures, and snap_valid stays high for each following cycle.
REQ-027 enable=0 freezes the live counters only; clear, snap_req and ovf retention still operate.
REQ-028 rd_data = shadow[rd_sel] combinationally, with zero latency.
REQ-029 rd_data = 0 when rd_sel >= NUM_CH.
REQ-030 Shadow registers are not affected by clear; they change only on snap_req or reset.
REQ-031 Channels are fully independent; simultaneous events on all channels all count on the same edge.

Reset
REQ-032 reset_n=0 asynchronously forces all live counters, shadow registers, ovf and snap_valid to 0.
REQ-033 Reset asserted mid-count or mid-snapshot discards that operation; there is no snap_valid pulse after reset release.
REQ-034 After reset_n deasserts, the first edge behaves as a normal functional edge.

Structure
REQ-035 Shared package perf_pkg holds the 2-bit event-mode enum (OFF, XFER, STALL, IDLE) and the default NUM_CH/CNT_W constants.
REQ-036 One sub-module, perf_counter_ch, holds one channel's event decode, counter, ovf flag and shadow register, and is instantiated NUM_CH times by generate.
REQ-037 The top level holds only snap_valid generation and the rd_sel read mux.

Verification
REQ-038 Wrap: CNT_W=4, SAT_MODE=0, ch0 XFER, 17 valid&ready cycles -> shadow[0]=1 after snapshot, ovf[0]=1.
REQ-039 Saturate: CNT_W=4, SAT_MODE=1, 20 events -> shadow=15, ovf=1; clear -> next snapshot reads 0 and ovf=0.
REQ-040 Modes: ch0..3 = XFER/STALL/IDLE/OFF, a 10-cycle pattern of 4 transfers, 3 stalls and 3 idles -> snapshot reads 4,3,3,0.
REQ-041 Collision: counter=7, snap_req+clear+event on one edge -> rd_data=7, live=0, snap_valid high on the next cycle.
REQ-042 Freeze and reset: enable=0 with events for 5 cycles -> values unchanged; reset_n pulsed mid-count -> all outputs 0 immediately, with no clk edge needed.
REQ-043 Read mux: NUM_CH=3, rd_sel=3 -> rd_data=0; each valid rd_sel returns its own shadow value in the same cycle.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank.
// Holds the per-channel event-select encoding and the default bank
// geometry used by perf_counter_bank and perf_counter_ch.
package perf_pkg;

    // Per-channel event select, carried on ch_mode[2i+1:2i]
    typedef enum logic [1:0] {
        OFF   = 2'd0,   // never counts
        XFER  = 2'd1,   // valid & ready
        STALL = 2'd2,   // valid & !ready
        IDLE  = 2'd3    // !valid
    } ev_mode_e;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_CNT_W  = 16;

endpackage : perf_pkg

// File: rtl/perf_counter_ch.sv
// One monitored valid/ready channel: event decode, live counter,
// sticky overflow flag and snapshot shadow register.
//
// Ports:
//   i_clk       clock, all state on rising edge
//   i_rst_n     asynchronous active-low reset
//   i_enable    count enable (does not gate clear or snapshot)
//   i_clear     synchronous clear of live counter and overflow flag
//   i_valid     channel source valid
//   i_ready     channel receiver ready
//   i_mode      event select (perf_pkg::ev_mode_e encoding)
//   i_snap_req  copy pre-edge live count into the shadow register
//   o_shadow    shadow register value
//   o_ovf       sticky overflow flag
module perf_counter_ch
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned SAT_MODE = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic             i_ready,
    input  logic [1:0]       i_mode,
    input  logic             i_snap_req,
    output logic [CNT_W-1:0] o_shadow,
    output logic             o_ovf
);

    ev_mode_e         w_mode;
    logic             w_event;
    logic             w_at_max;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_shadow;
    logic             r_ovf;

    assign w_mode   = ev_mode_e'(i_mode);
    assign w_at_max = (r_cnt == '1);

    // Decode uses the current-cycle mode, so a mode change applies on this edge
    always_comb begin
        w_event = 1'b0;
        unique case (w_mode)
            OFF:   w_event = 1'b0;
            XFER:  w_event = i_valid & i_ready;
            STALL: w_event = i_valid & ~i_ready;
            IDLE:  w_event = ~i_valid;
        endcase
    end

    // Clear wins over increment and swallows the same-cycle event
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_enable && w_event) begin
            if (w_at_max) begin
                r_ovf <= 1'b1;
                if (SAT_MODE == 0) begin
                    r_cnt <= '0;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Shadow samples the pre-edge count and ignores clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow <= '0;
        end else if (i_snap_req) begin
            r_shadow <= r_cnt;
        end
    end

    assign o_shadow = r_shadow;
    assign o_ovf    = r_ovf;

endmodule : perf_counter_ch

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH independent valid/ready event counters with a common
// snapshot mechanism and a zero-latency shadow read port.
//
// Ports:
//   clk         clock, all state on rising edge
//   reset_n     asynchronous active-low reset
//   enable      global count enable
//   clear       synchronous clear of live counters and overflow flags
//   valid       per-channel source valid
//   ready       per-channel receiver ready
//   ch_mode     per-channel event select, channel i at [2i+1:2i]
//   snap_req    copy all live counters into the shadow registers
//   rd_sel      shadow register read index
//   rd_data     shadow value of the selected channel (0 if out of range)
//   snap_valid  one-cycle pulse following each sampled snap_req
//   ovf         sticky per-channel overflow flags
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter  int unsigned NUM_CH   = DEF_NUM_CH,
    parameter  int unsigned CNT_W    = DEF_CNT_W,
    parameter  int unsigned SAT_MODE = 0,
    localparam int unsigned SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                clear,
    input  logic [NUM_CH-1:0]   valid,
    input  logic [NUM_CH-1:0]   ready,
    input  logic [2*NUM_CH-1:0] ch_mode,
    input  logic                snap_req,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [CNT_W-1:0]    rd_data,
    output logic                snap_valid,
    output logic [NUM_CH-1:0]   ovf
);

    logic [CNT_W-1:0] w_shadow [NUM_CH];
    logic             r_snap_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        perf_counter_ch #(
            .CNT_W    (CNT_W),
            .SAT_MODE (SAT_MODE)
        ) u_ch (
            .i_clk      (clk),
            .i_rst_n    (reset_n),
            .i_enable   (enable),
            .i_clear    (clear),
            .i_valid    (valid[g]),
            .i_ready    (ready[g]),
            .i_mode     (ch_mode[2*g+1:2*g]),
            .i_snap_req (snap_req),
            .o_shadow   (w_shadow[g]),
            .o_ovf      (ovf[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= snap_req;
        end
    end

    assign snap_valid = r_snap_valid;

    // Compare-based mux keeps out-of-range selects (non power-of-two banks) at zero
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data = w_shadow[i];
            end
        end
    end

endmodule : perf_counter_bank

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank. Three instances share one
// stimulus stream: A (4 ch, 4 bit, wrap), B (4 ch, 4 bit, saturate),
// C (3 ch, 8 bit, wrap). A counting model predicts every output.
module tb_perf_counter_bank;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       clear;
    logic       snap_req;
    logic [3:0] valid;
    logic [3:0] ready;
    logic [7:0] ch_mode;
    logic [1:0] rd_sel;

    logic [3:0] rd_a, rd_b, ovf_a, ovf_b;
    logic [7:0] rd_c;
    logic [2:0] ovf_c;
    logic       sv_a, sv_b, sv_c;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Model state per instance (k = 0:A, 1:B, 2:C)
    int unsigned m_live [3][4];
    int unsigned m_sh   [3][4];
    bit          m_ovf  [3][4];
    bit          m_sv   [3];

    perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .SAT_MODE(0)) u_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .valid(valid), .ready(ready), .ch_mode(ch_mode), .snap_req(snap_req),
        .rd_sel(rd_sel), .rd_data(rd_a), .snap_valid(sv_a), .ovf(ovf_a)
    );

    perf_counter_bank #(.NUM_CH(4), .CNT_W(4), .SAT_MODE(1)) u_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .valid(valid), .ready(ready), .ch_mode(ch_mode), .snap_req(snap_req),
        .rd_sel(rd_sel), .rd_data(rd_b), .snap_valid(sv_b), .ovf(ovf_b)
    );

    perf_counter_bank #(.NUM_CH(3), .CNT_W(8), .SAT_MODE(0)) u_c (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .valid(valid[2:0]), .ready(ready[2:0]), .ch_mode(ch_mode[5:0]),
        .snap_req(snap_req), .rd_sel(rd_sel), .rd_data(rd_c),
        .snap_valid(sv_c), .ovf(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance geometry ----------------
    function automatic int unsigned nch(int k);
        return (k == 2) ? 3 : 4;
    endfunction

    function automatic int unsigned cw(int k);
        return (k == 2) ? 8 : 4;
    endfunction

    function automatic bit sat(int k);
        return (k == 1);
    endfunction

    // ---------------- DUT accessors ----------------
    function automatic logic [31:0] dut_rd(int k);
        if (k == 0) return {28'd0, rd_a};
        if (k == 1) return {28'd0, rd_b};
        return {24'd0, rd_c};
    endfunction

    function automatic logic [31:0] dut_ovf(int k);
        if (k == 0) return {28'd0, ovf_a};
        if (k == 1) return {28'd0, ovf_b};
        return {29'd0, ovf_c};
    endfunction

    function automatic logic dut_sv(int k);
        if (k == 0) return sv_a;
        if (k == 1) return sv_b;
        return sv_c;
    endfunction

    // ---------------- reference model ----------------
    function automatic bit ev(int unsigned mode, bit v, bit r);
        case (mode)
            1:       return v && r;
            2:       return v && !r;
            3:       return !v;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(int k, int unsigned sel);
        return (sel < nch(k)) ? m_sh[k][sel] : 0;
    endfunction

    function automatic logic [31:0] exp_ovf(int k);
        logic [31:0] v = '0;
        for (int i = 0; i < 4; i++) v[i] = m_ovf[k][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_sv[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_live[k][i] = 0;
                m_sh[k][i]   = 0;
                m_ovf[k][i]  = 1'b0;
            end
        end
    endtask

    // Predict the effect of the coming rising edge from the current inputs
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < nch(k); i++) begin
                int unsigned md;
                longint unsigned top, nxt;
                md  = (ch_mode >> (2 * i)) & 3;
                top = (64'd1 << cw(k)) - 1;
                if (snap_req) m_sh[k][i] = m_live[k][i];
                if (clear) begin
                    m_live[k][i] = 0;
                    m_ovf[k][i]  = 1'b0;
                end else if (enable && ev(md, valid[i], ready[i])) begin
                    nxt = longint'(m_live[k][i]) + 1;
                    if (nxt > top) begin
                        m_ovf[k][i] = 1'b1;
                        nxt = sat(k) ? top : 0;
                    end
                    m_live[k][i] = int'(nxt);
                end
            end
            m_sv[k] = snap_req;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; clear = 1'b0; snap_req = 1'b0;
        valid = '0; ready = '0; ch_mode = '0; rd_sel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            #1;
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (dut_rd(k) !== 0) begin
                    n_fail++;
                    $display("FAIL reset_rd k=%0d sel=%0d got=%0h exp=0", k, s, dut_rd(k));
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (dut_ovf(k) !== 0 || dut_sv(k) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags k=%0d ovf=%0h sv=%0b exp=0/0", k, dut_ovf(k), dut_sv(k));
            end
        end
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        clear = 1'b1; tick(); clear = 1'b0;
        ch_mode = 8'h01; valid = '1; ready = '1;
        repeat (17) tick();
        valid = '0; ready = '0;
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        rd_sel = 2'd0;
        #1;
        n_chk++;
        if (rd_a !== 4'd1 || ovf_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_a got rd=%0d ovf=%0b exp rd=1 ovf=1", rd_a, ovf_a[0]);
        end
        n_chk++;
        if (rd_c !== 8'd17 || ovf_c[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_c got rd=%0d ovf=%0b exp rd=17 ovf=0", rd_c, ovf_c[0]);
        end
        n_chk++;
        if (sv_a !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_snap_valid got=%0b exp=1", sv_a);
        end
        tick();
        n_chk++;
        if (sv_a !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_snap_pulse got=%0b exp=0", sv_a);
        end
    endtask

    task automatic test_saturate();
        clear = 1'b1; tick(); clear = 1'b0;
        ch_mode = 8'h01; valid = '1; ready = '1;
        repeat (20) tick();
        valid = '0; ready = '0;
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        rd_sel = 2'd0;
        #1;
        n_chk++;
        if (rd_b !== 4'd15 || ovf_b[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_b got rd=%0d ovf=%0b exp rd=15 ovf=1", rd_b, ovf_b[0]);
        end
        n_chk++;
        if (rd_a !== 4'd4 || ovf_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_a_wrap got rd=%0d ovf=%0b exp rd=4 ovf=1", rd_a, ovf_a[0]);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        n_chk++;
        if (ovf_b !== 4'd0 || rd_b !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_clear got ovf=%0h rd=%0d exp ovf=0 rd=15", ovf_b, rd_b);
        end
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        n_chk++;
        if (rd_b !== 4'd0) begin
            n_fail++;
            $display("FAIL sat_after_clear got=%0d exp=0", rd_b);
        end
    endtask

    task automatic test_modes();
        int unsigned pat [10];
        clear = 1'b1; tick(); clear = 1'b0;
        ch_mode = 8'b00_11_10_01;  // ch3 OFF, ch2 IDLE, ch1 STALL, ch0 XFER
        foreach (pat[j]) pat[j] = (j < 4) ? 0 : (j < 7) ? 1 : 2;
        for (int j = 9; j > 0; j--) begin
            int unsigned r, t;
            r = $urandom_range(j, 0);
            t = pat[j]; pat[j] = pat[r]; pat[r] = t;
        end
        foreach (pat[j]) begin
            valid = (pat[j] == 2) ? 4'h0 : 4'hF;
            ready = (pat[j] == 0) ? 4'hF : 4'h0;
            tick();
        end
        valid = '0; ready = '1; ch_mode = '0;
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        for (int s = 0; s < 4; s++) begin
            logic [3:0] ea;
            logic [7:0] ec;
            rd_sel = 2'(s);
            #1;
            ea = (s == 0) ? 4'd4 : (s == 3) ? 4'd0 : 4'd3;
            ec = (s == 0) ? 8'd4 : (s == 3) ? 8'd0 : 8'd3;
            n_chk++;
            if (rd_a !== ea || rd_c !== ec) begin
                n_fail++;
                $display("FAIL modes sel=%0d got a=%0d c=%0d exp a=%0d c=%0d", s, rd_a, rd_c, ea, ec);
            end
        end
    endtask

    task automatic test_collision();
        clear = 1'b1; tick(); clear = 1'b0;
        ch_mode = 8'h01; valid = '1; ready = '1;
        repeat (7) tick();
        snap_req = 1'b1; clear = 1'b1;
        tick();
        snap_req = 1'b0; clear = 1'b0; valid = '0;
        rd_sel = 2'd0;
        #1;
        n_chk++;
        if (rd_a !== 4'd7 || rd_c !== 8'd7 || sv_a !== 1'b1) begin
            n_fail++;
            $display("FAIL collision got a=%0d c=%0d sv=%0b exp 7/7/1", rd_a, rd_c, sv_a);
        end
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        n_chk++;
        if (rd_a !== 4'd0 || rd_c !== 8'd0) begin
            n_fail++;
            $display("FAIL collision_live got a=%0d c=%0d exp 0/0", rd_a, rd_c);
        end
    endtask

    task automatic test_back_to_back();
        ch_mode = 8'h55; valid = '1; ready = '1;
        rd_sel = 2'd1;
        snap_req = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (dut_sv(k) !== 1'b1 || dut_rd(k) !== exp_rd(k, 1)) begin
                    n_fail++;
                    $display("FAIL b2b j=%0d k=%0d got sv=%0b rd=%0d exp sv=1 rd=%0d",
                             j, k, dut_sv(k), dut_rd(k), exp_rd(k, 1));
                end
            end
        end
        snap_req = 1'b0;
        tick();
        n_chk++;
        if (sv_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end got=%0b exp=0", sv_a);
        end
    endtask

    task automatic test_freeze_reset();
        enable = 1'b0; ch_mode = 8'hE4;  // one of each mode
        for (int j = 0; j < 5; j++) begin
            valid = 4'($urandom); ready = 4'($urandom);
            tick();
        end
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            #1;
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (dut_rd(k) !== exp_rd(k, s) || dut_ovf(k) !== exp_ovf(k)) begin
                    n_fail++;
                    $display("FAIL freeze k=%0d sel=%0d got rd=%0d ovf=%0h exp rd=%0d ovf=%0h",
                             k, s, dut_rd(k), dut_ovf(k), exp_rd(k, s), exp_ovf(k));
                end
            end
        end
        enable = 1'b1; valid = '1; ready = '1; ch_mode = 8'h55;
        repeat (3) tick();
        snap_req = 1'b1;
        #2;
        reset_n = 1'b0;  // mid-cycle, between clock edges
        model_reset();
        #1;
        n_chk++;
        if (rd_a !== 0 || rd_b !== 0 || rd_c !== 0 || ovf_a !== 0 || ovf_b !== 0 ||
            ovf_c !== 0 || sv_a !== 0 || sv_b !== 0 || sv_c !== 0) begin
            n_fail++;
            $display("FAIL async_reset got a=%0d b=%0d c=%0d ovf=%0h/%0h/%0h sv=%0b%0b%0b exp all 0",
                     rd_a, rd_b, rd_c, ovf_a, ovf_b, ovf_c, sv_a, sv_b, sv_c);
        end
        @(posedge clk);
        #1;
        snap_req = 1'b0;
        reset_n  = 1'b1;
        tick();
        n_chk++;
        if (sv_a !== 1'b0 || sv_c !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_pulse got sv=%0b%0b exp 00", sv_a, sv_c);
        end
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        rd_sel = 2'd0;
        #1;
        n_chk++;
        if (rd_a !== 4'd1 || rd_c !== 8'd1) begin
            n_fail++;
            $display("FAIL first_edge got a=%0d c=%0d exp 1/1", rd_a, rd_c);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            enable   = ($urandom_range(7, 0) != 0);
            clear    = ($urandom_range(31, 0) == 0);
            snap_req = ($urandom_range(3, 0) == 0);
            valid    = 4'($urandom);
            ready    = 4'($urandom);
            if ($urandom_range(7, 0) == 0) ch_mode = 8'($urandom);
            rd_sel   = 2'($urandom);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (dut_rd(k) !== exp_rd(k, rd_sel) || dut_sv(k) !== m_sv[k] ||
                    dut_ovf(k) !== exp_ovf(k)) begin
                    n_fail++;
                    $display("FAIL random j=%0d k=%0d sel=%0d got rd=%0d sv=%0b ovf=%0h exp rd=%0d sv=%0b ovf=%0h",
                             j, k, rd_sel, dut_rd(k), dut_sv(k), dut_ovf(k),
                             exp_rd(k, rd_sel), m_sv[k], exp_ovf(k));
                end
            end
        end
        clear = 1'b0; snap_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_modes();
        test_collision();
        test_back_to_back();
        test_freeze_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_perf_counter_bank
